// File: rtl/divider_seq.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor, one quotient
// bit per clock over eight iterations, with a single-cycle divide-by-zero path.
module divider_seq (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] Z,
  input  logic [3:0] Y,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic       state_dbg
);

  // Handshake: start is a request sampled only in IDLE (busy=0); the result
  // is valid for exactly the cycle done=1 and Q/R/div_by_zero hold until the next done.
  typedef enum logic {IDLE, CALC} state_t;

  state_t     state;
  logic [7:0] dvd;
  logic [3:0] dvs;
  logic [3:0] rem;
  logic [7:0] quo;
  logic [2:0] cnt;

  logic [4:0] p;
  logic       ge;
  logic [3:0] diff;
  logic [3:0] rem_nxt;
  logic [7:0] quo_nxt;

  // rem < divisor keeps p - divisor below 16 whenever it is taken,
  // so a 4-bit modular subtract is exact.
  always_comb begin
    p       = {rem, dvd[7]};
    ge      = (p >= {1'b0, dvs});
    diff    = p[3:0] - dvs;
    rem_nxt = ge ? diff : p[3:0];
    quo_nxt = {quo[6:0], ge};
  end

  assign state_dbg = (state == CALC);

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (Y != 4'd0) begin
              dvd   <= Z;
              dvs   <= Y;
              rem   <= '0;
              quo   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              Q           <= 8'hFF;
              R           <= 4'h0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end
          end
        end
        CALC: begin
          dvd <= {dvd[6:0], 1'b0};
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            Q           <= quo_nxt;
            R           <= rem_nxt;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: vector table of quotient/remainder/latency,
// hand-written sequences for reset, busy protection, and a full Z/Y sweep.
module tb_divider_seq;

  logic       clock_100Mhz = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] Z;
  logic [3:0] Y;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       state_dbg;

  int passed = 0;
  int total  = 0;

  logic [12:0] exp_q[$];

  typedef struct {
    logic [7:0] z;
    logic [3:0] y;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  divider_seq dut (
    .clock_100Mhz(clock_100Mhz),
    .reset(reset),
    .start(start),
    .Z(Z),
    .Y(Y),
    .Q(Q),
    .R(R),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic tick();
    @(posedge clock_100Mhz);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // driver: one start strobe, then wait (bounded) for done
  task automatic run_op(input logic [7:0] z, input logic [3:0] y,
                        output int lat, output bit busy_seen, output bit overlap);
    Z = z;
    Y = y;
    start = 1'b1;
    busy_seen = 1'b0;
    overlap = 1'b0;
    lat = 0;
    tick();
    start = 1'b0;
    while (!done && lat < 20) begin
      if (busy) busy_seen = 1'b1;
      tick();
      lat++;
    end
    if (done && busy) overlap = 1'b1;
  endtask

  initial begin
    int         lat;
    bit         bs;
    bit         ov;
    int         dcount;
    int         sweep_err;
    logic [7:0] q_at_done;
    logic [3:0] r_at_done;
    logic [12:0] exp_v;

    vecs[0]  = '{8'd225, 4'd15, 8'd15,  4'd0, 1'b0, 8};
    vecs[1]  = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8};
    vecs[2]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8};
    vecs[3]  = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 8};
    vecs[4]  = '{8'd42,  4'd0,  8'hFF,  4'd0, 1'b1, 0};
    vecs[5]  = '{8'd42,  4'd6,  8'd7,   4'd0, 1'b0, 8};
    vecs[6]  = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8};
    vecs[7]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};
    vecs[8]  = '{8'd128, 4'd11, 8'd11,  4'd7, 1'b0, 8};
    vecs[9]  = '{8'd7,   4'd0,  8'hFF,  4'd0, 1'b1, 0};
    vecs[10] = '{8'd100, 4'd3,  8'd33,  4'd1, 1'b0, 8};

    // reset held low with live inputs and start
    reset = 1'b0;
    start = 1'b1;
    Z = 8'd0;
    Y = 4'd0;
    for (int i = 0; i < 6; i++) begin
      Z = 8'($urandom_range(0, 255));
      Y = 4'($urandom_range(0, 15));
      tick();
      check("reset_hold", int'({Q, R, busy, done, div_by_zero}), 0);
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    check("post_reset_idle", int'({Q, R, busy, done, div_by_zero, state_dbg}), 0);

    // vector table
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back({vecs[i].q, vecs[i].r, vecs[i].dbz});
      run_op(vecs[i].z, vecs[i].y, lat, bs, ov);
      exp_v = exp_q.pop_front();
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_Q", i), int'(Q), int'(exp_v[12:5]));
      check($sformatf("v%0d_R", i), int'(R), int'(exp_v[4:1]));
      check($sformatf("v%0d_dbz", i), int'(div_by_zero), int'(exp_v[0]));
      check($sformatf("v%0d_busy_seen", i), int'(bs), int'(vecs[i].y != 4'd0));
      check($sformatf("v%0d_done_with_busy", i), int'(ov), 0);
      tick();
      check($sformatf("v%0d_done_pulse_low", i), int'(done), 0);
      check($sformatf("v%0d_hold", i), int'({Q, R, div_by_zero}), int'(exp_v));
    end

    // back-to-back divide by zero pulses done every cycle
    Z = 8'd3;
    Y = 4'd0;
    start = 1'b1;
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done && !busy) dcount++;
    end
    start = 1'b0;
    check("dbz_back_to_back", dcount, 4);
    tick();

    // busy protection: second start mid-operation is ignored
    Z = 8'd100;
    Y = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    Z = 8'd9;
    Y = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    q_at_done = '0;
    r_at_done = '0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        if (dcount == 0) begin
          q_at_done = Q;
          r_at_done = R;
        end
        dcount++;
      end
      tick();
    end
    check("busy_prot_done_count", dcount, 1);
    check("busy_prot_Q", int'(q_at_done), 33);
    check("busy_prot_R", int'(r_at_done), 1);

    // reset during the fifth iteration
    Z = 8'd200;
    Y = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_busy_before_reset", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_reset_clear", int'({Q, R, busy, done, div_by_zero, state_dbg}), 0);
    tick();
    tick();
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    check("mid_reset_no_done", dcount, 0);
    run_op(8'd77, 4'd5, lat, bs, ov);
    check("after_reset_latency", lat, 8);
    check("after_reset_Q", int'(Q), 15);
    check("after_reset_R", int'(R), 2);
    tick();

    // full sweep of nonzero divisors
    sweep_err = 0;
    for (int z = 0; z < 256; z++) begin
      for (int y = 1; y < 16; y++) begin
        run_op(8'(z), 4'(y), lat, bs, ov);
        if (!done || div_by_zero || (int'(Q) * y + int'(R) != z) || (int'(R) >= y)
            || int'(Q) != z / y) begin
          if (sweep_err < 4)
            $display("sweep z=%0d y=%0d got Q=%0d R=%0d done=%0d", z, y, Q, R, done);
          sweep_err++;
        end
      end
    end
    check("sweep_errors", sweep_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential restoring divider: the inverse of the registered 4x4 multiplier. Accepts an 8-bit dividend and a 4-bit divisor on a start strobe. Produces an 8-bit quotient and a 4-bit remainder after a fixed 8-iteration datapath, one quotient bit per clock. Sits alongside the multiplier on the Basys3 board so a product can be divided back by one operand to check it.

## Interface
- No parameters; widths fixed: dividend 8, divisor 4, quotient 8, remainder 4.
- Clock: one clock, `clock_100Mhz`. Reset: `reset`, asynchronous and active-low.
- clock_100Mhz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; clears all state and outputs.
- start  input  1  request strobe; sampled only while idle.
- Z  input  8  dividend; sampled on the accepting edge only.
- Y  input  4  divisor; sampled on the accepting edge only.
- Q  output  8  quotient; registered, holds until the next completion.
- R  output  4  remainder; registered, holds until the next completion.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when Q/R are updated.
- div_by_zero  output  1  set with done when Y was 0; holds until the next completion.

## Operation
- States: IDLE, CALC.
- IDLE, start=1, Y!=0:
  - latch Z into the dividend shift register and Y into the divisor register;
  - partial remainder (5-bit) = 0; iteration counter = 0;
  - go to CALC; busy=1.
- IDLE, start=1, Y==0:
  - stay in IDLE; Q=8'hFF, R=4'h0, div_by_zero=1, done=1 for one cycle;
  - no CALC cycles.
- IDLE, start=0: hold; done=0.
- CALC, each edge:
  - p = {rem[3:0], dividend_msb}; dividend shifts left by one;
  - if p >= {1'b0,divisor}: rem = p - divisor, shift 1 into quotient LSB;
  - else: rem = p, shift 0 into quotient LSB;
  - counter increments.
- CALC, 8th iteration (counter==7):
  - final quotient/remainder go to Q/R; div_by_zero=0; done=1; busy=0;
  - return to IDLE.
- start asserted while busy is ignored; Z/Y changes during CALC have no effect.
- Arithmetic: all unsigned. Invariant at done with Y!=0: Q*Y + R == Z and R < Y.
- Q, R and div_by_zero are only written on completion; they hold otherwise.

## Timing
- Reset asserted (reset=0) at any time, including mid-CALC:
  - immediately Q=0, R=0, busy=0, done=0, div_by_zero=0; state IDLE; internal registers 0;
  - the in-flight operation is lost.
- First accepting edge after reset deassertion behaves normally.
- Latency, Y!=0: start sampled at edge E0 → busy high after E0 → done high for exactly one cycle after E8 with Q/R valid → busy low after E8.
- Throughput, Y!=0: a new start can be accepted at E9 → one operation per 9 cycles when start is held high.
- Y==0: done and div_by_zero valid after E0 (latency 1); busy never asserts. Back-to-back start with Y==0 pulses done every cycle.
- done never asserts while busy=1 in the same cycle.

## Test plan
- Reset: hold reset=0 with random inputs and start=1 → Q=0, R=0, busy=0, done=0, div_by_zero=0 throughout.
- Basic: Z=8'd225, Y=4'd15, start one cycle → busy for 8 cycles, then done pulse with Q=15, R=0, div_by_zero=0.
- Remainder and extremes:
  - Z=8'd200, Y=4'd7 → Q=28, R=4;
  - Z=8'd255, Y=4'd1 → Q=255, R=0;
  - Z=8'd5, Y=4'd9 → Q=0, R=5.
- Divide by zero: Z=8'd42, Y=0, start → next cycle done=1, Q=8'hFF, R=0, div_by_zero=1, busy never high. Then Z=42, Y=6 → Q=7, R=0, div_by_zero cleared.
- Busy protection: start Z=100, Y=3; at cycle 4 change to Z=9, Y=2 and pulse start again → done once, Q=33, R=1; no second done until a fresh start is issued from IDLE.
- Reset mid-operation and exhaustive check:
  - assert reset at iteration 5 → outputs clear, no done pulse; a fresh start then completes normally;
  - sweep all 256×15 Z/Y pairs with nonzero Y, checking Q*Y+R==Z and R<Y.
